// File: rtl/commit_packer_pkg.sv
// -----------------------------------------------------------------------------
// commit_packer_pkg
//   Shared types and constants for the commit trace packer.
//   - pk_state_e : packer FSM states (PK_IDLE, PK_COLLECT)
//   - PK_BEAT_W  : width of one vector payload beat
//   - PK_*_W     : field widths of the commit uop bundle
//   - pk_nbeats  : number of 64-bit beats carrying a VLEN*8-bit payload
// -----------------------------------------------------------------------------
package commit_packer_pkg;

    typedef enum logic [0:0] {
        PK_IDLE    = 1'b0,
        PK_COLLECT = 1'b1
    } pk_state_e;

    localparam int PK_BEAT_W  = 64;
    localparam int PK_PC_W    = 40;
    localparam int PK_TAG_W   = 64;
    localparam int PK_LDST_W  = 5;
    localparam int PK_RTYPE_W = 3;
    localparam int PK_INST_W  = 32;

    // Vector payload is VLEN*8 bits wide, split into PK_BEAT_W-bit beats.
    function automatic int pk_nbeats(input int vlen);
        return (vlen * 8) / PK_BEAT_W;
    endfunction

endpackage

// File: rtl/commit_tag_checker.sv
// -----------------------------------------------------------------------------
// commit_tag_checker
//   Watches the emitted commit stream and flags a break in the debug-tag
//   sequence. The first tag after reset seeds the expectation; every later
//   commit must carry previous tag + 1. The error is sticky until reset.
//   Only instantiated when COMMIT_PACKER_TAG_CHECK_EN is defined.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   commit_valid in  one-cycle commit pulse
//   commit_tag  in   tag carried by the commit
//   tag_err     out  sticky sequence error
// -----------------------------------------------------------------------------
module commit_tag_checker
    import commit_packer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                commit_valid,
    input  logic [PK_TAG_W-1:0] commit_tag,
    output logic                tag_err
);

    logic                seen_reg;
    logic [PK_TAG_W-1:0] exp_tag_reg;
    logic                err_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            seen_reg    <= 1'b0;
            exp_tag_reg <= '0;
            err_reg     <= 1'b0;
        end else if (commit_valid) begin
            seen_reg    <= 1'b1;
            exp_tag_reg <= commit_tag + 1'b1;
            if (seen_reg && (commit_tag != exp_tag_reg)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign tag_err = err_reg;

endmodule

// File: rtl/commit_trace_packer.sv
// -----------------------------------------------------------------------------
// commit_trace_packer
//   Assembles committed-uop headers (plus, for vector writes, a stream of
//   64-bit payload beats) into the flat commit_* bundle and emits each record
//   as a one-cycle commit_arch_valids_0 pulse. All outputs are registered.
// Optional feature:
//   COMMIT_PACKER_TAG_CHECK_EN - when defined, a commit_tag_checker drives
//   tag_err; otherwise tag_err is tied low.
// Ports:
//   clock, reset                 rising-edge clock, sync active-low reset
//   in_valid / in_ready          header handshake (ready only in IDLE)
//   in_pc/inst/tag/ldst/rtype/wdata/vec/vec_wmask  header fields
//   beat_valid / beat_ready      payload beat handshake (ready only in COLLECT)
//   beat_data                    64-bit payload beat
//   commit_arch_valids_0         one-cycle commit pulse
//   commit_uops_0_*              registered record fields
//   tag_err                      sticky tag-sequence error
// -----------------------------------------------------------------------------
module commit_trace_packer
    import commit_packer_pkg::*;
#(
    parameter int VLEN = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PK_PC_W-1:0]      in_pc,
    input  logic [PK_INST_W-1:0]    in_inst,
    input  logic [PK_TAG_W-1:0]     in_tag,
    input  logic [PK_LDST_W-1:0]    in_ldst,
    input  logic [PK_RTYPE_W-1:0]   in_rtype,
    input  logic [63:0]             in_wdata,
    input  logic                    in_vec,
    input  logic [7:0]              in_vec_wmask,
    input  logic                    beat_valid,
    output logic                    beat_ready,
    input  logic [PK_BEAT_W-1:0]    beat_data,
    output logic                    commit_arch_valids_0,
    output logic [PK_LDST_W-1:0]    commit_uops_0_ldst,
    output logic [PK_RTYPE_W-1:0]   commit_uops_0_dst_rtype,
    output logic [PK_PC_W-1:0]      commit_uops_0_debug_pc,
    output logic [PK_INST_W-1:0]    commit_uops_0_debug_inst,
    output logic [PK_TAG_W-1:0]     commit_uops_0_debug_tag,
    output logic [63:0]             commit_uops_0_debug_wdata,
    output logic [VLEN*8-1:0]       commit_uops_0_debug_vec_wdata,
    output logic [7:0]              commit_uops_0_debug_vec_wmask,
    output logic                    tag_err
);

    localparam int NBEATS = pk_nbeats(VLEN);
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [0:0] ST_IDLE    = 1'(PK_IDLE);
    localparam logic [0:0] ST_COLLECT = 1'(PK_COLLECT);

    logic [0:0]            state_reg, state_next;
    logic [CNT_W-1:0]      beat_cnt_reg, beat_cnt_next;
    logic                  arch_valid_reg, arch_valid_next;

    logic [PK_LDST_W-1:0]  ldst_reg;
    logic [PK_RTYPE_W-1:0] rtype_reg;
    logic [PK_PC_W-1:0]    pc_reg;
    logic [PK_INST_W-1:0]  inst_reg;
    logic [PK_TAG_W-1:0]   tag_reg;
    logic [63:0]           wdata_reg;
    logic [7:0]            wmask_reg;
    logic [PK_BEAT_W-1:0]  vec_slice_reg [NBEATS];
    logic [NBEATS-1:0]     slice_we;

    logic hdr_fire;
    logic beat_fire;
    logic last_beat;

    assign hdr_fire  = in_valid && (state_reg == ST_IDLE);
    assign beat_fire = beat_valid && (state_reg == ST_COLLECT);
    assign last_beat = beat_fire && (beat_cnt_reg == CNT_W'(NBEATS - 1));

    // One write-enable per payload slice, decoded from the beat counter.
    generate
        for (genvar gi = 0; gi < NBEATS; gi++) begin : g_slice
            assign slice_we[gi] = beat_fire && (beat_cnt_reg == CNT_W'(gi));
            assign commit_uops_0_debug_vec_wdata[gi*PK_BEAT_W +: PK_BEAT_W] = vec_slice_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        beat_cnt_next   = beat_cnt_reg;
        arch_valid_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (hdr_fire) begin
                    if (in_vec) begin
                        state_next    = ST_COLLECT;
                        beat_cnt_next = '0;
                    end else begin
                        arch_valid_next = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (last_beat) begin
                    // Explicit wrap: NBEATS need not be a power of two.
                    arch_valid_next = 1'b1;
                    state_next      = ST_IDLE;
                    beat_cnt_next   = '0;
                end else if (beat_fire) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            beat_cnt_reg   <= '0;
            arch_valid_reg <= 1'b0;
            ldst_reg       <= '0;
            rtype_reg      <= '0;
            pc_reg         <= '0;
            inst_reg       <= '0;
            tag_reg        <= '0;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
            for (int i = 0; i < NBEATS; i++) begin
                vec_slice_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            beat_cnt_reg   <= beat_cnt_next;
            arch_valid_reg <= arch_valid_next;
            if (hdr_fire) begin
                ldst_reg  <= in_ldst;
                rtype_reg <= in_rtype;
                pc_reg    <= in_pc;
                inst_reg  <= in_inst;
                tag_reg   <= in_tag;
                wdata_reg <= in_wdata;
                wmask_reg <= in_vec_wmask;
            end
            // Header clears the payload; a slice is only written in COLLECT,
            // so the two enables never coincide.
            for (int i = 0; i < NBEATS; i++) begin
                if (hdr_fire) begin
                    vec_slice_reg[i] <= '0;
                end else if (slice_we[i]) begin
                    vec_slice_reg[i] <= beat_data;
                end
            end
        end
    end

    assign in_ready                      = (state_reg == ST_IDLE);
    assign beat_ready                    = (state_reg == ST_COLLECT);
    assign commit_arch_valids_0          = arch_valid_reg;
    assign commit_uops_0_ldst            = ldst_reg;
    assign commit_uops_0_dst_rtype       = rtype_reg;
    assign commit_uops_0_debug_pc        = pc_reg;
    assign commit_uops_0_debug_inst      = inst_reg;
    assign commit_uops_0_debug_tag       = tag_reg;
    assign commit_uops_0_debug_wdata     = wdata_reg;
    assign commit_uops_0_debug_vec_wmask = wmask_reg;

`ifdef COMMIT_PACKER_TAG_CHECK_EN
    commit_tag_checker u_tag_checker (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (arch_valid_reg),
        .commit_tag   (tag_reg),
        .tag_err      (tag_err)
    );
`else
    assign tag_err = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_packer.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_packer
//   Self-checking bench for commit_trace_packer (VLEN=256, 32 beats).
//   A transaction-level model predicts every commit record and the cycle in
//   which its pulse must appear; outputs are sampled on the falling edge.
//   Directed table vectors and hand-written sequences cover the corner cases,
//   followed by a randomized mix of scalar and vector commits.
// -----------------------------------------------------------------------------
module tb_commit_trace_packer;

    localparam int VLEN   = 256;
    localparam int NBEATS = VLEN / 8;
    localparam int VEC_W  = VLEN * 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [39:0]      in_pc;
    logic [31:0]      in_inst;
    logic [63:0]      in_tag;
    logic [4:0]       in_ldst;
    logic [2:0]       in_rtype;
    logic [63:0]      in_wdata;
    logic             in_vec;
    logic [7:0]       in_vec_wmask;
    logic             beat_valid;
    logic             beat_ready;
    logic [63:0]      beat_data;
    logic             commit_arch_valids_0;
    logic [4:0]       commit_uops_0_ldst;
    logic [2:0]       commit_uops_0_dst_rtype;
    logic [39:0]      commit_uops_0_debug_pc;
    logic [31:0]      commit_uops_0_debug_inst;
    logic [63:0]      commit_uops_0_debug_tag;
    logic [63:0]      commit_uops_0_debug_wdata;
    logic [VEC_W-1:0] commit_uops_0_debug_vec_wdata;
    logic [7:0]       commit_uops_0_debug_vec_wmask;
    logic             tag_err;

    commit_trace_packer #(.VLEN(VLEN)) dut (
        .clock                         (clock),
        .reset                         (reset),
        .in_valid                      (in_valid),
        .in_ready                      (in_ready),
        .in_pc                         (in_pc),
        .in_inst                       (in_inst),
        .in_tag                        (in_tag),
        .in_ldst                       (in_ldst),
        .in_rtype                      (in_rtype),
        .in_wdata                      (in_wdata),
        .in_vec                        (in_vec),
        .in_vec_wmask                  (in_vec_wmask),
        .beat_valid                    (beat_valid),
        .beat_ready                    (beat_ready),
        .beat_data                     (beat_data),
        .commit_arch_valids_0          (commit_arch_valids_0),
        .commit_uops_0_ldst            (commit_uops_0_ldst),
        .commit_uops_0_dst_rtype       (commit_uops_0_dst_rtype),
        .commit_uops_0_debug_pc        (commit_uops_0_debug_pc),
        .commit_uops_0_debug_inst      (commit_uops_0_debug_inst),
        .commit_uops_0_debug_tag       (commit_uops_0_debug_tag),
        .commit_uops_0_debug_wdata     (commit_uops_0_debug_wdata),
        .commit_uops_0_debug_vec_wdata (commit_uops_0_debug_vec_wdata),
        .commit_uops_0_debug_vec_wmask (commit_uops_0_debug_vec_wmask),
        .tag_err                       (tag_err)
    );

    always #5 clock = ~clock;

    // Expected commit record plus the tick index of its pulse.
    typedef struct {
        logic [39:0]      pc;
        logic [31:0]      inst;
        logic [63:0]      tag;
        logic [4:0]       ldst;
        logic [2:0]       rtype;
        logic [63:0]      wdata;
        logic             vec;
        logic [7:0]       wmask;
        logic [VEC_W-1:0] vdata;
        int               due;
    } rec_t;

    // Directed scalar vector: header inputs and the outputs they must produce.
    typedef struct {
        logic [39:0] pc;
        logic [63:0] tag;
        logic [63:0] wdata;
        logic [4:0]  ldst;
        logic [39:0] exp_pc;
        logic [63:0] exp_tag;
        logic [63:0] exp_wdata;
        logic [4:0]  exp_ldst;
    } tv_t;

    int          total;
    int          bad;
    int          cyc;
    rec_t        exp_q[$];
    bit          m_busy;
    rec_t        m_pend;
    int          m_beats;
    bit          m_hdr_acc;
    bit          m_beat_acc;
    bit          m_err;
    bit          m_have;
    logic [63:0] m_last;
    logic [63:0] beat_src [NBEATS];

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [VEC_W-1:0] want);
        total++;
        if (commit_uops_0_debug_vec_wdata !== want) begin
            bad++;
            for (int k = 0; k < NBEATS; k++) begin
                if (commit_uops_0_debug_vec_wdata[64*k +: 64] !== want[64*k +: 64]) begin
                    $display("FAIL %s cyc=%0d beat=%0d got=%h want=%h", nm, cyc, k,
                             commit_uops_0_debug_vec_wdata[64*k +: 64], want[64*k +: 64]);
                    break;
                end
            end
        end
    endtask

    // Falling-edge monitor: pulse timing, handshake readiness, record content.
    task automatic check_outputs();
        bit   exp_pulse;
        rec_t r;
        exp_pulse = (exp_q.size() != 0) && (exp_q[0].due == cyc);
        chk("pulse", 256'(commit_arch_valids_0), 256'(exp_pulse));
        chk("in_ready", 256'(in_ready), 256'(!m_busy));
        chk("beat_ready", 256'(beat_ready), 256'(m_busy));
        chk("tag_err", 256'(tag_err), 256'(m_err));
        if (exp_pulse) begin
            r = exp_q.pop_front();
            if (commit_arch_valids_0 === 1'b1) begin
                chk("record_hdr",
                    256'({commit_uops_0_ldst, commit_uops_0_dst_rtype, commit_uops_0_debug_pc,
                          commit_uops_0_debug_inst, commit_uops_0_debug_tag, commit_uops_0_debug_wdata}),
                    256'({r.ldst, r.rtype, r.pc, r.inst, r.tag, r.wdata}));
                chk("record_wmask", 256'(commit_uops_0_debug_vec_wmask), 256'(r.wmask));
                chk_vec("record_vec", r.vdata);
            end
`ifdef COMMIT_PACKER_TAG_CHECK_EN
            if (m_have && (r.tag != m_last + 64'd1)) m_err = 1'b1;
            m_last = r.tag;
            m_have = 1'b1;
`endif
        end
    endtask

    // One clock cycle: monitor, advance the model by the handshakes that the
    // coming rising edge will perform, then step past the edge.
    task automatic tick();
        rec_t r;
        @(negedge clock);
        check_outputs();
        m_hdr_acc  = 1'b0;
        m_beat_acc = 1'b0;
        if (!reset) begin
            m_busy = 1'b0;
            exp_q.delete();
            m_err  = 1'b0;
            m_have = 1'b0;
        end else if (in_valid && !m_busy) begin
            m_hdr_acc = 1'b1;
            r.pc = in_pc; r.inst = in_inst; r.tag = in_tag; r.ldst = in_ldst;
            r.rtype = in_rtype; r.wdata = in_wdata; r.vec = in_vec;
            r.wmask = in_vec_wmask; r.vdata = '0; r.due = cyc + 1;
            if (in_vec) begin
                m_pend  = r;
                m_busy  = 1'b1;
                m_beats = 0;
            end else begin
                exp_q.push_back(r);
            end
        end else if (beat_valid && m_busy) begin
            m_beat_acc = 1'b1;
            m_pend.vdata[64*m_beats +: 64] = beat_data;
            m_beats++;
            if (m_beats == NBEATS) begin
                m_pend.due = cyc + 1;
                exp_q.push_back(m_pend);
                m_busy = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic rec_t mk(input logic [63:0] tag, input bit vec);
        rec_t r;
        r.pc = {8'h80, $urandom}; r.inst = $urandom; r.tag = tag;
        r.ldst = 5'($urandom); r.rtype = 3'($urandom);
        r.wdata = {$urandom, $urandom}; r.vec = vec; r.wmask = 8'($urandom);
        r.vdata = '0; r.due = 0;
        return r;
    endfunction

    task automatic set_hdr(input rec_t r);
        in_pc = r.pc; in_inst = r.inst; in_tag = r.tag; in_ldst = r.ldst;
        in_rtype = r.rtype; in_wdata = r.wdata; in_vec = r.vec; in_vec_wmask = r.wmask;
    endtask

    task automatic do_header(input rec_t r, input bit keep);
        set_hdr(r);
        in_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (m_hdr_acc) break;
        end
        if (!m_hdr_acc) begin
            total++; bad++;
            $display("FAIL header_timeout cyc=%0d got=not_accepted want=accepted", cyc);
        end
        if (!keep) in_valid = 1'b0;
    endtask

    // gap_mode: 0 none, 1 idle cycle before every beat, 2 random idle cycles.
    task automatic do_beats(input int gap_mode, input int upto);
        for (int k = 0; k < upto; k++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                beat_valid = 1'b0;
                beat_data  = {$urandom, $urandom};
                tick();
            end
            beat_valid = 1'b1;
            beat_data  = beat_src[k];
            for (int n = 0; n < 400; n++) begin
                tick();
                if (m_beat_acc) break;
            end
            if (!m_beat_acc) begin
                total++; bad++;
                $display("FAIL beat_timeout cyc=%0d got=not_accepted want=accepted", cyc);
            end
        end
        beat_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, 256'(commit_arch_valids_0), 256'(0));
        chk({nm, "_uops"},
            256'({commit_uops_0_ldst, commit_uops_0_dst_rtype, commit_uops_0_debug_pc,
                  commit_uops_0_debug_inst, commit_uops_0_debug_tag, commit_uops_0_debug_wdata,
                  commit_uops_0_debug_vec_wmask, tag_err}), 256'(0));
        chk_vec({nm, "_vec"}, '0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        tv_t              tbl [6];
        rec_t             rv;
        rec_t             rs;
        logic [VEC_W-1:0] ev;
        logic [63:0]      tag;
        logic [63:0]      tl [3];
        bit               isvec;

        total = 0; bad = 0; cyc = 0;
        m_busy = 1'b0; m_beats = 0; m_err = 1'b0; m_have = 1'b0; m_last = '0;
        m_hdr_acc = 1'b0; m_beat_acc = 1'b0;
        reset = 1'b0; in_valid = 1'b0; beat_valid = 1'b0; beat_data = '0;
        in_pc = '0; in_inst = '0; in_tag = '0; in_ldst = '0; in_rtype = '0;
        in_wdata = '0; in_vec = 1'b0; in_vec_wmask = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset_state");
        chk("reset_in_ready", 256'(in_ready), 256'(1));
        chk("reset_beat_ready", 256'(beat_ready), 256'(0));
        reset = 1'b1;

        // Back-to-back scalar headers, first one is the canonical example.
        tbl[0] = '{40'h00_8000_0000, 64'd1, 64'hDEAD,     5'd1,  40'h00_8000_0000, 64'd1, 64'hDEAD,     5'd1};
        tbl[1] = '{40'h00_8000_0004, 64'd2, 64'h1234,     5'd2,  40'h00_8000_0004, 64'd2, 64'h1234,     5'd2};
        tbl[2] = '{40'h00_8000_0008, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 40'h00_8000_0008, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31};
        tbl[3] = '{40'hFF_FFFF_FFFC, 64'd4, 64'h0,        5'd0,  40'hFF_FFFF_FFFC, 64'd4, 64'h0,        5'd0};
        tbl[4] = '{40'h00_0000_0000, 64'd5, 64'hA5A5_5A5A_0F0F_F0F0, 5'd17, 40'h00_0000_0000, 64'd5, 64'hA5A5_5A5A_0F0F_F0F0, 5'd17};
        tbl[5] = '{40'h12_3456_789A, 64'd6, 64'h8000_0000_0000_0001, 5'd9, 40'h12_3456_789A, 64'd6, 64'h8000_0000_0000_0001, 5'd9};
        in_vec = 1'b0; in_inst = 32'h0000_0013; in_rtype = 3'd1; in_vec_wmask = 8'h00;
        for (int i = 0; i < 6; i++) begin
            in_pc = tbl[i].pc; in_tag = tbl[i].tag; in_wdata = tbl[i].wdata; in_ldst = tbl[i].ldst;
            in_valid = 1'b1;
            tick();
            chk("tbl_valid", 256'(commit_arch_valids_0), 256'(1));
            chk("tbl_fields",
                256'({commit_uops_0_debug_pc, commit_uops_0_debug_tag, commit_uops_0_debug_wdata, commit_uops_0_ldst}),
                256'({tbl[i].exp_pc, tbl[i].exp_tag, tbl[i].exp_wdata, tbl[i].exp_ldst}));
            chk_vec("tbl_vec_zero", '0);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_pulse_drops", 256'(commit_arch_valids_0), 256'(0));
        chk("b2b_tag_err", 256'(tag_err), 256'(0));

        // Vector with contiguous beats, data = beat index.
        rv = mk(64'd7, 1'b1);
        do_header(rv, 1'b0);
        for (int k = 0; k < NBEATS; k++) beat_src[k] = 64'(k);
        do_beats(0, NBEATS);
        ev = '0;
        for (int k = 0; k < NBEATS; k++) ev[64*k +: 64] = 64'(k);
        chk("vec_idx_valid", 256'(commit_arch_valids_0), 256'(1));
        chk_vec("vec_idx_data", ev);
        chk("vec_idx_wmask", 256'(commit_uops_0_debug_vec_wmask), 256'(rv.wmask));
        tick();
        chk("vec_idx_single_pulse", 256'(commit_arch_valids_0), 256'(0));

        // Gapped vector while the next scalar header waits with in_valid high.
        rv = mk(64'd8, 1'b1);
        rs = mk(64'd9, 1'b0);
        do_header(rv, 1'b1);
        set_hdr(rs);
        for (int k = 0; k < NBEATS; k++) beat_src[k] = {$urandom, $urandom};
        do_beats(1, NBEATS);
        chk("gap_vec_tag", 256'(commit_uops_0_debug_tag), 256'(rv.tag));
        chk("gap_in_ready_after", 256'(in_ready), 256'(1));
        do_header(rs, 1'b0);
        chk("gap_next_scalar_tag", 256'(commit_uops_0_debug_tag), 256'(rs.tag));

        // Reset after beat 10 discards the partial record.
        do_header(mk(64'd10, 1'b1), 1'b0);
        for (int k = 0; k < NBEATS; k++) beat_src[k] = {$urandom, $urandom};
        do_beats(0, 10);
        beat_valid = 1'b1;
        beat_data  = beat_src[10];
        reset = 1'b0;
        tick();
        reset = 1'b1;
        beat_valid = 1'b0;
        chk_all_zero("reset_mid");
        chk("reset_mid_in_ready", 256'(in_ready), 256'(1));
        rs = mk(64'd11, 1'b0);
        do_header(rs, 1'b0);
        chk("post_reset_scalar", 256'({commit_arch_valids_0, commit_uops_0_debug_tag}), 256'({1'b1, rs.tag}));

`ifdef COMMIT_PACKER_TAG_CHECK_EN
        // Tag gap 6 -> 8 must raise a sticky error the cycle after the pulse.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tl[0] = 64'd5; tl[1] = 64'd6; tl[2] = 64'd8;
        for (int i = 0; i < 3; i++) begin
            set_hdr(mk(tl[i], 1'b0));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("tagchk_before", 256'(tag_err), 256'(0));
        tick();
        chk("tagchk_rise", 256'(tag_err), 256'(1));
        repeat (5) tick();
        chk("tagchk_sticky", 256'(tag_err), 256'(1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("tagchk_cleared", 256'(tag_err), 256'(0));
`endif

        // Randomized mix checked by the model.
        tag = 64'd100;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid   = 1'b0;
                beat_valid = 1'($urandom);
                beat_data  = {$urandom, $urandom};
                repeat ($urandom_range(1, 3)) tick();
                beat_valid = 1'b0;
            end
            tag   = ($urandom_range(0, 7) == 0) ? tag + 64'd2 : tag + 64'd1;
            isvec = ($urandom_range(0, 2) == 0);
            do_header(mk(tag, isvec), 1'b0);
            if (isvec) begin
                for (int k = 0; k < NBEATS; k++) beat_src[k] = {$urandom, $urandom};
                do_beats(2, NBEATS);
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("all_commits_seen", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
